// File: rtl/pix_pack_wr.sv
`default_nettype none
// ============================================================================
//  Module   : pix_pack_wr
//  Purpose  : Frame-buffer write-side feeder. Accepts a narrow pixel stream
//             (valid/ready with sof/eof flags), packs PIX_PER_WORD pixels
//             into one DATA_WIDTH word and hands each word to the frame
//             buffer with an active-low write strobe. Enforces a per-frame
//             word limit, flags overflow and pulses on frame completion.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   single clock
//    reset      in   asynchronous active-low reset
//    pix_valid  in   pixel present
//    pix_data   in   pixel value [PIX_WIDTH-1:0]
//    pix_sof    in   pixel is first of a frame
//    pix_eof    in   pixel is last of a frame
//    pix_rdy    out  pixel accepted on an edge when pix_valid && pix_rdy
//    out_stall  in   active-high downstream hold
//    wr_en_out  out  active-low write strobe (frame buffer wr_en_in)
//    data_out   out  packed word [DATA_WIDTH-1:0] (frame buffer data_in)
//    frame_done out  one-cycle pulse per completed frame
//    overflow   out  sticky: frame exceeded FRAME_WORDS
//    word_cnt   out  words handed off in the current frame [CNT_WIDTH-1:0]
//  Build option
//    PIX_PACK_PARTIAL_FLUSH_EN : when defined, an eof that leaves a word
//    partially filled emits it zero-padded; otherwise partial lanes are
//    discarded.
// ============================================================================
module pix_pack_wr #(
   parameter int DATA_WIDTH  = 32,
   parameter int PIX_WIDTH   = 8,
   parameter int FRAME_WORDS = 500,
   parameter int CNT_WIDTH   = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pix_valid,
   input  logic [PIX_WIDTH-1:0]  pix_data,
   input  logic                  pix_sof,
   input  logic                  pix_eof,
   output logic                  pix_rdy,
   input  logic                  out_stall,
   output logic                  wr_en_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_done,
   output logic                  overflow,
   output logic [CNT_WIDTH-1:0]  word_cnt
);

   localparam int PIX_PER_WORD = DATA_WIDTH / PIX_WIDTH;
   localparam int LANE_W       = $clog2(PIX_PER_WORD);

   localparam logic [LANE_W-1:0]  c_LAST_LANE   = LANE_W'(PIX_PER_WORD - 1);
   localparam logic [CNT_WIDTH-1:0] c_FRAME_CNT = CNT_WIDTH'(FRAME_WORDS);
   localparam logic [CNT_WIDTH:0] c_FRAME_LIMIT = (CNT_WIDTH + 1)'(FRAME_WORDS);

`ifdef PIX_PACK_PARTIAL_FLUSH_EN
   localparam logic c_FLUSH = 1'b1;
`else
   localparam logic c_FLUSH = 1'b0;
`endif

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PACK = 1'b1
   } state_t;

   state_t                r_state;
   logic [LANE_W-1:0]     r_lane;
   logic [DATA_WIDTH-1:0] r_pack;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_pending;
   logic                  r_overflow;
   logic                  r_frame_done;
   logic [CNT_WIDTH-1:0]  r_word_cnt;

   state_t                w_state_n;
   logic [LANE_W-1:0]     w_lane_n;
   logic [DATA_WIDTH-1:0] w_pack_n;
   logic [DATA_WIDTH-1:0] w_data_n;
   logic                  w_pending_n;
   logic                  w_ovf_n;
   logic                  w_done_n;
   logic [CNT_WIDTH-1:0]  w_cnt_n;

   logic                  w_handoff;
   logic                  w_accept;
   logic [LANE_W-1:0]     w_base_lane;
   logic [DATA_WIDTH-1:0] w_word;
   logic [CNT_WIDTH:0]    w_cnt_eff;
   logic                  w_full;
   logic                  w_emit;

   // A word leaves whenever one is pending and downstream is not holding.
   assign w_handoff  = r_pending & ~out_stall;
   assign pix_rdy    = ~r_pending | ~out_stall;
   assign w_accept   = pix_valid & pix_rdy;

   assign wr_en_out  = ~w_handoff;
   assign data_out   = r_data;
   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;
   assign word_cnt   = r_word_cnt;

   always_comb begin
      w_state_n   = r_state;
      w_lane_n    = r_lane;
      w_pack_n    = r_pack;
      w_data_n    = r_data;
      w_pending_n = r_pending & ~w_handoff;
      w_ovf_n     = r_overflow;
      w_done_n    = 1'b0;
      w_cnt_n     = r_word_cnt;
      w_base_lane = r_lane;
      w_word      = r_pack;
      w_full      = 1'b0;
      w_emit      = 1'b0;
      // Count as it will stand after this edge's handoff, so the limit
      // check sees a word that is leaving on the same edge.
      w_cnt_eff   = {1'b0, r_word_cnt} + (CNT_WIDTH + 1)'(w_handoff);

      if (w_handoff && (r_word_cnt != c_FRAME_CNT)) begin
         w_cnt_n = r_word_cnt + CNT_WIDTH'(1);
      end

      if (w_accept) begin
         // sof restarts the frame; a word handing off on this edge belongs
         // to the old frame, so the clear takes priority over its count.
         if (pix_sof) begin
            w_base_lane = '0;
            w_word      = '0;
            w_cnt_eff   = '0;
            w_cnt_n     = '0;
            w_ovf_n     = 1'b0;
         end

         // In IDLE only an sof pixel opens a frame; anything else is dropped.
         if (pix_sof || (r_state == ST_PACK)) begin
            for (int i = 0; i < PIX_PER_WORD; i++) begin
               if (w_base_lane == LANE_W'(i)) begin
                  w_word[i*PIX_WIDTH +: PIX_WIDTH] = pix_data;
               end
            end

            w_full = (w_base_lane == c_LAST_LANE);
            w_emit = w_full | (pix_eof & c_FLUSH);

            if (w_emit) begin
               if (w_cnt_eff < c_FRAME_LIMIT) begin
                  w_data_n    = w_word;
                  w_pending_n = 1'b1;
               end else begin
                  w_ovf_n = 1'b1;
               end
            end

            if (w_full || pix_eof) begin
               w_lane_n = '0;
               w_pack_n = '0;
            end else begin
               w_lane_n = w_base_lane + LANE_W'(1);
               w_pack_n = w_word;
            end

            if (pix_eof) begin
               w_state_n = ST_IDLE;
               w_done_n  = 1'b1;
            end else begin
               w_state_n = ST_PACK;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_lane       <= '0;
         r_pack       <= '0;
         r_data       <= '0;
         r_pending    <= 1'b0;
         r_overflow   <= 1'b0;
         r_frame_done <= 1'b0;
         r_word_cnt   <= '0;
      end else begin
         r_state      <= w_state_n;
         r_lane       <= w_lane_n;
         r_pack       <= w_pack_n;
         r_data       <= w_data_n;
         r_pending    <= w_pending_n;
         r_overflow   <= w_ovf_n;
         r_frame_done <= w_done_n;
         r_word_cnt   <= w_cnt_n;
      end
   end

endmodule
`default_nettype wire

// File: doc/pix_pack_wr.md
Name: pix_pack_wr

Overview:
- Upstream feeder for the frame buffer write side.
- Accepts a narrow pixel stream with valid/ready, start-of-frame and end-of-frame flags, and packs PIX_PER_WORD pixels into one DATA_WIDTH word.
- Presents each packed word with an active-low write strobe, matching the frame buffer's data_in/wr_en_in interface.
- Enforces a per-frame word limit and reports overflow and frame completion.

Parameters:
- DATA_WIDTH, 32, packed word width; must equal the frame buffer DATA_WIDTH.
- PIX_WIDTH, 8, pixel width; DATA_WIDTH/PIX_WIDTH must be an integer >= 2 (PIX_PER_WORD).
- FRAME_WORDS, 500, maximum words written per frame; matches the frame buffer BUF_SIZE.
- CNT_WIDTH, 9, word counter width; must hold FRAME_WORDS.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pixel present.
- pix_data  in  PIX_WIDTH  pixel value.
- pix_sof  in  1  qualifies the pixel as first of a frame.
- pix_eof  in  1  qualifies the pixel as last of a frame.
- pix_rdy  out  1  pixel accepted at a rising edge when pix_valid && pix_rdy.
- out_stall  in  1  active-high downstream hold; no handoff while high.
- wr_en_out  out  1  active-low write strobe to the frame buffer wr_en_in.
- data_out  out  DATA_WIDTH  packed word to the frame buffer data_in.
- frame_done  out  1  one-cycle pulse per completed frame.
- overflow  out  1  sticky flag: frame exceeded FRAME_WORDS.
- word_cnt  out  CNT_WIDTH  words handed off in the current frame.

Behaviour:
- Reset (asynchronous, active-low; takes effect immediately, including mid-word or with a word pending):
  - State = IDLE, lane count = 0, pending = 0.
  - wr_en_out = 1 (deasserted), data_out = 0, frame_done = 0, overflow = 0, word_cnt = 0; pix_rdy reads 1.
- Lane packing: the first accepted pixel of a word goes to bits [PIX_WIDTH-1:0]; lane i goes to [PIX_WIDTH*(i+1)-1 : PIX_WIDTH*i].
- States:
  - IDLE:
    - Accepted pixels without pix_sof are discarded; pix_rdy remains governed by the rule below.
    - An accepted pixel with pix_sof loads lane 0, clears word_cnt and overflow, and moves to PACK.
    - sof && eof on the same pixel is a one-pixel frame and is handled as eof.
  - PACK:
    - Each accepted pixel fills the next lane.
    - When the last lane is filled, the word is loaded into data_out and pending is set on the same edge, unless word_cnt == FRAME_WORDS. In that case the word is dropped, overflow is set, and word_cnt holds.
    - A pix_sof pixel accepted in PACK discards any partial lanes, clears word_cnt and overflow, loads lane 0, and stays in PACK. A pending word is still handed off.
    - An accepted pix_eof pixel ends the frame: lanes reset, return to IDLE, frame_done = 1 for the single following cycle. If the eof pixel fills the last lane, the word is emitted normally.
- Handoff:
  - wr_en_out = 0 combinationally whenever pending && !out_stall.
  - On the edge ending that cycle, pending clears and word_cnt increments.
  - data_out is stable for as long as pending is set.
  - Unstalled latency: last pixel accepted at edge N; wr_en_out is low for exactly the cycle after edge N.
- pix_rdy = !pending || (pending && !out_stall). pix_rdy does not depend on pix_valid, pix_sof or pix_eof.
- Continuous unstalled input sustains one word every PIX_PER_WORD cycles, with no bubbles.
- overflow stays set until the next sof or reset. word_cnt saturates at FRAME_WORDS.

Optional Feature:
- Macro: PIX_PACK_PARTIAL_FLUSH_EN.
- Defined:
  - An eof pixel that leaves the word partially filled causes a zero-padded word (unfilled lanes = 0) to be loaded and pended on the same edge.
  - This word follows the same FRAME_WORDS limit and overflow rules as a full word.
- Undefined: partial lanes at eof are discarded; no write occurs for them.

Test Plan:
- Reset, then sof 0x11, 0x22, 0x33, 0x44 on consecutive cycles, out_stall = 0 -> wr_en_out low for one cycle, data_out = 0x44332211, word_cnt = 1.
- Form a word with out_stall = 1 held for 5 cycles -> wr_en_out stays 1, pix_rdy = 0, data_out held; release stall -> one low strobe, pix_rdy = 1 in the same cycle.
- sof 0xAA, then eof 0xBB:
  - Without the macro -> no strobe, frame_done pulses once.
  - With the macro -> one strobe, data_out = 0x0000BBAA, then frame_done.
- FRAME_WORDS = 4, send 6 full words -> exactly 4 strobes, overflow = 1, word_cnt = 4; next sof -> overflow = 0, word_cnt = 0.
- sof 0x01, 0x02, 0x03, then sof 0x10, 0x20, 0x30, 0x40 -> single strobe, data_out = 0x40302010.
- Assert reset while a word is pending with stall -> wr_en_out = 1 immediately; after release, no stale write, pix_rdy = 1, word_cnt = 0.
